// File: rtl/fft_sample_loader.sv
// Streams complex samples into FFT ping-pong bank 0, zero-fills short frames and kicks off the FFT.
// Define FFT_LOADER_BITREV_EN to write in bit-reversed address order (in-place DIT input ordering).
module fft_sample_loader #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned N          = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [DATA_WIDTH-1:0]     s_re,
    input  logic [DATA_WIDTH-1:0]     s_im,
    input  logic                      s_last,
    output logic                      mem_we,
    output logic [$clog2(N)-1:0]      mem_addr,
    output logic [2*DATA_WIDTH-1:0]   mem_wdata,
    output logic                      fft_start,
    input  logic                      fft_finish,
    output logic                      busy,
    output logic                      len_err,
    output logic [7:0]                frame_cnt
);

    localparam int unsigned AW = $clog2(N);
    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    typedef enum logic [2:0] {
        LOAD  = 3'd0,
        FILL  = 3'd1,
        DRAIN = 3'd2,
        START = 3'd3,
        WAIT  = 3'd4
    } state_t;

    state_t          state;
    logic [AW-1:0]   idx;
    logic [AW-1:0]   wr_addr_c;
    logic            hs_c;

`ifdef FFT_LOADER_BITREV_EN
    function automatic logic [AW-1:0] bit_reverse(input logic [AW-1:0] v);
        logic [AW-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < AW; i++) begin
            r[i] = v[AW-1-i];
        end
        return r;
    endfunction

    assign wr_addr_c = bit_reverse(idx);
`else
    assign wr_addr_c = idx;
`endif

    assign hs_c = s_valid && s_ready;

    // s_ready and busy are registered alongside every state change so they track the state exactly
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= LOAD;
            idx       <= '0;
            s_ready   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            fft_start <= 1'b0;
            busy      <= 1'b0;
            len_err   <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            mem_we    <= 1'b0;
            fft_start <= 1'b0;
            case (state)
                LOAD: begin
                    s_ready <= 1'b1;
                    if (hs_c) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= wr_addr_c;
                        mem_wdata <= {s_re, s_im};
                        idx       <= idx + AW'(1);
                        if (idx == LAST_IDX) begin
                            state   <= DRAIN;
                            s_ready <= 1'b0;
                            busy    <= 1'b1;
                            if (!s_last) begin
                                len_err <= 1'b1;
                            end
                        end else if (s_last) begin
                            state   <= FILL;
                            s_ready <= 1'b0;
                            busy    <= 1'b1;
                            len_err <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    mem_we    <= 1'b1;
                    mem_addr  <= wr_addr_c;
                    mem_wdata <= '0;
                    idx       <= idx + AW'(1);
                    if (idx == LAST_IDX) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    state     <= START;
                    fft_start <= 1'b1;
                end
                START: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (fft_finish) begin
                        frame_cnt <= frame_cnt + 8'd1;
                        idx       <= '0;
                        state     <= LOAD;
                        s_ready   <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state   <= LOAD;
                    idx     <= '0;
                    s_ready <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_sample_loader.sv
// Randomized self-checking bench for fft_sample_loader against a frame-level reference model.
module tb_fft_sample_loader;

    localparam int unsigned DW = 16;
    localparam int unsigned N  = 8;
    localparam int unsigned AW = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [DW-1:0]     s_re = '0;
    logic [DW-1:0]     s_im = '0;
    logic              s_last = 1'b0;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [2*DW-1:0]   mem_wdata;
    logic              fft_start;
    logic              fft_finish = 1'b0;
    logic              busy;
    logic              len_err;
    logic [7:0]        frame_cnt;

    fft_sample_loader #(.DATA_WIDTH(DW), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_re(s_re), .s_im(s_im), .s_last(s_last), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .fft_start(fft_start),
        .fft_finish(fft_finish), .busy(busy), .len_err(len_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int last_hs = 0;

    logic [AW-1:0]   waddr_q[$];
    logic [2*DW-1:0] wdata_q[$];
    int              start_q[$];
    logic [DW-1:0]   re_a[N];
    logic [DW-1:0]   im_a[N];

    // Observe the memory port and start pulse mid-cycle
    always @(negedge clk) begin
        if (mem_we) begin
            waddr_q.push_back(mem_addr);
            wdata_q.push_back(mem_wdata);
        end
        if (fft_start) start_q.push_back(cyc);
    end

    function automatic logic [AW-1:0] exp_addr(input int i);
`ifdef FFT_LOADER_BITREV_EN
        int v;
        int r;
        v = i;
        r = 0;
        for (int b = 0; b < int'(AW); b++) begin
            r = r * 2 + v % 2;
            v = v / 2;
        end
        return AW'(r);
`else
        return AW'(i);
`endif
    endfunction

    function automatic logic [2*DW-1:0] exp_data(input int i, input int len);
        if (i < len) return {re_a[i], im_a[i]};
        return '0;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < int'(N); i++) begin
            re_a[i] = DW'($urandom);
            im_a[i] = DW'($urandom);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; fft_finish = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Present sample i until accepted; the handshake edge follows the negedge where s_ready is seen high
    task automatic send(input int i, input bit last, input int gap);
        bit got;
        int t;
        repeat (gap) @(negedge clk);
        s_valid = 1'b1; s_re = re_a[i]; s_im = im_a[i]; s_last = last;
        got = 1'b0;
        t = 0;
        while (!got && t < 50) begin
            if (s_ready === 1'b1) begin
                last_hs = cyc;
                got = 1'b1;
            end
            @(negedge clk);
            t++;
        end
        s_valid = 1'b0; s_last = 1'b0;
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL handshake_timeout: sample %0d never accepted within 50 cycles", i);
        end
    endtask

    task automatic load_frame(input int len, input bit last_flag, input int gap);
        waddr_q.delete(); wdata_q.delete(); start_q.delete();
        for (int i = 0; i < len; i++) send(i, last_flag && (i == len - 1), gap);
        repeat (N + 6) @(negedge clk);
        #1;
    endtask

    task automatic finish_pulse();
        fft_finish = 1'b1;
        @(negedge clk);
        fft_finish = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; s_valid = 1'b1; s_last = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL rst_s_ready: got %b want 0", s_ready); end
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
        n_cmp++; if (mem_addr !== '0) begin n_bad++; $display("FAIL rst_mem_addr: got %0h want 0", mem_addr); end
        n_cmp++; if (mem_wdata !== '0) begin n_bad++; $display("FAIL rst_mem_wdata: got %0h want 0", mem_wdata); end
        n_cmp++; if (fft_start !== 1'b0) begin n_bad++; $display("FAIL rst_fft_start: got %b want 0", fft_start); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (len_err !== 1'b0) begin n_bad++; $display("FAIL rst_len_err: got %b want 0", len_err); end
        n_cmp++; if (frame_cnt !== 8'd0) begin n_bad++; $display("FAIL rst_frame_cnt: got %0d want 0", frame_cnt); end
        s_valid = 1'b0; s_last = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL rel_s_ready: got %b want 1", s_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rel_busy: got %b want 0", busy); end
    endtask

    task automatic test_full_frame();
        do_reset();
        for (int i = 0; i < int'(N); i++) begin re_a[i] = DW'(i); im_a[i] = '0; end
        load_frame(N, 1'b1, 0);
        n_cmp++; if (waddr_q.size() != N) begin n_bad++; $display("FAIL full_wr_count: got %0d want %0d", waddr_q.size(), N); end
        for (int i = 0; i < int'(N) && i < int'(waddr_q.size()); i++) begin
            n_cmp++;
            if (waddr_q[i] !== exp_addr(i) || wdata_q[i] !== exp_data(i, N)) begin
                n_bad++;
                $display("FAIL full_write[%0d]: got %0h/%0h want %0h/%0h", i, waddr_q[i], wdata_q[i], exp_addr(i), exp_data(i, N));
            end
        end
        n_cmp++;
        if (start_q.size() != 1 || start_q[0] != last_hs + 2) begin
            n_bad++; $display("FAIL full_start: got %0d pulses first@%0d want 1 @%0d", start_q.size(), (start_q.size() > 0) ? start_q[0] : -1, last_hs + 2);
        end
        n_cmp++; if (len_err !== 1'b0) begin n_bad++; $display("FAIL full_len_err: got %b want 0", len_err); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL full_busy_wait: got %b want 1", busy); end
        finish_pulse();
        n_cmp++; if (frame_cnt !== 8'd1) begin n_bad++; $display("FAIL full_frame_cnt: got %0d want 1", frame_cnt); end
        n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL full_ready_after: got %b want 1", s_ready); end
    endtask

    task automatic test_short_frame();
        do_reset();
        fill_random();
        load_frame(3, 1'b1, 0);
        n_cmp++; if (waddr_q.size() != N) begin n_bad++; $display("FAIL short_wr_count: got %0d want %0d", waddr_q.size(), N); end
        for (int i = 0; i < int'(N) && i < int'(waddr_q.size()); i++) begin
            n_cmp++;
            if (waddr_q[i] !== exp_addr(i) || wdata_q[i] !== exp_data(i, 3)) begin
                n_bad++;
                $display("FAIL short_write[%0d]: got %0h/%0h want %0h/%0h", i, waddr_q[i], wdata_q[i], exp_addr(i), exp_data(i, 3));
            end
        end
        n_cmp++;
        if (start_q.size() != 1 || start_q[0] != last_hs + 7) begin
            n_bad++; $display("FAIL short_start: got %0d pulses first@%0d want 1 @%0d", start_q.size(), (start_q.size() > 0) ? start_q[0] : -1, last_hs + 7);
        end
        n_cmp++; if (len_err !== 1'b1) begin n_bad++; $display("FAIL short_len_err: got %b want 1", len_err); end
        finish_pulse();
        n_cmp++; if (len_err !== 1'b1) begin n_bad++; $display("FAIL short_len_err_sticky: got %b want 1", len_err); end
    endtask

    task automatic test_gaps();
        int n_before;
        do_reset();
        fill_random();
        load_frame(N, 1'b1, 1);
        n_cmp++; if (waddr_q.size() != N) begin n_bad++; $display("FAIL gap_wr_count: got %0d want %0d", waddr_q.size(), N); end
        for (int i = 0; i < int'(N) && i < int'(waddr_q.size()); i++) begin
            n_cmp++;
            if (waddr_q[i] !== exp_addr(i) || wdata_q[i] !== exp_data(i, N)) begin
                n_bad++;
                $display("FAIL gap_write[%0d]: got %0h/%0h want %0h/%0h", i, waddr_q[i], wdata_q[i], exp_addr(i), exp_data(i, N));
            end
        end
        // Upstream pushes during WAIT must not be taken
        n_before = waddr_q.size();
        s_valid = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL wait_ready: got %b want 0", s_ready); end
        n_cmp++; if (waddr_q.size() != n_before) begin n_bad++; $display("FAIL wait_writes: got %0d want %0d", waddr_q.size(), n_before); end
        s_valid = 1'b0;
        finish_pulse();
    endtask

    task automatic test_finish_ignored();
        do_reset();
        fill_random();
        @(negedge clk);
        finish_pulse();
        n_cmp++; if (frame_cnt !== 8'd0) begin n_bad++; $display("FAIL load_finish_cnt: got %0d want 0", frame_cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL load_finish_busy: got %b want 0", busy); end
        waddr_q.delete(); wdata_q.delete(); start_q.delete();
        for (int i = 0; i < 4; i++) send(i, 1'b0, 0);
        finish_pulse();
        @(negedge clk);
        for (int i = 4; i < int'(N); i++) send(i, i == int'(N) - 1, 0);
        repeat (N + 6) @(negedge clk);
        #1;
        n_cmp++; if (waddr_q.size() != N) begin n_bad++; $display("FAIL midfin_wr_count: got %0d want %0d", waddr_q.size(), N); end
        for (int i = 0; i < int'(N) && i < int'(waddr_q.size()); i++) begin
            n_cmp++;
            if (waddr_q[i] !== exp_addr(i) || wdata_q[i] !== exp_data(i, N)) begin
                n_bad++;
                $display("FAIL midfin_write[%0d]: got %0h/%0h want %0h/%0h", i, waddr_q[i], wdata_q[i], exp_addr(i), exp_data(i, N));
            end
        end
        n_cmp++; if (frame_cnt !== 8'd0) begin n_bad++; $display("FAIL midfin_cnt: got %0d want 0", frame_cnt); end
        finish_pulse();
        n_cmp++; if (frame_cnt !== 8'd1) begin n_bad++; $display("FAIL wait_finish_cnt: got %0d want 1", frame_cnt); end
        n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL wait_finish_ready: got %b want 1", s_ready); end
    endtask

    task automatic test_random_frames();
        int  len;
        bit  last_flag;
        bit  exp_err;
        int  exp_cnt;
        do_reset();
        exp_err = 1'b0;
        exp_cnt = 0;
        for (int f = 0; f < 8; f++) begin
            fill_random();
            len = int'($urandom_range(1, N));
            last_flag = (len < int'(N)) ? 1'b1 : 1'($urandom_range(0, 1));
            exp_err = exp_err || (len < int'(N)) || !last_flag;
            load_frame(len, last_flag, int'($urandom_range(0, 2)));
            for (int i = 0; i < int'(N); i++) begin
                n_cmp++;
                if (i >= int'(waddr_q.size()) || waddr_q[i] !== exp_addr(i) || wdata_q[i] !== exp_data(i, len)) begin
                    n_bad++;
                    $display("FAIL rnd_write f%0d[%0d]: got %0d writes, want %0h/%0h", f, i, waddr_q.size(), exp_addr(i), exp_data(i, len));
                end
            end
            n_cmp++;
            if (start_q.size() != 1 || start_q[0] != last_hs + 2 + int'(N) - len) begin
                n_bad++; $display("FAIL rnd_start f%0d: got %0d pulses first@%0d want @%0d", f, start_q.size(), (start_q.size() > 0) ? start_q[0] : -1, last_hs + 2 + int'(N) - len);
            end
            n_cmp++; if (len_err !== exp_err) begin n_bad++; $display("FAIL rnd_len_err f%0d: got %b want %b", f, len_err, exp_err); end
            finish_pulse();
            exp_cnt = (exp_cnt + 1) % 256;
            n_cmp++; if (frame_cnt !== 8'(exp_cnt)) begin n_bad++; $display("FAIL rnd_cnt f%0d: got %0d want %0d", f, frame_cnt, exp_cnt); end
        end
    endtask

    task automatic test_wrap();
        int len;
        do_reset();
        for (int f = 0; f < 256; f++) begin
            fill_random();
            len = int'($urandom_range(1, N));
            load_frame(len, 1'b1, 0);
            finish_pulse();
            n_cmp++;
            if (frame_cnt !== 8'((f + 1) % 256)) begin
                n_bad++; $display("FAIL wrap_cnt f%0d: got %0d want %0d", f, frame_cnt, (f + 1) % 256);
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        fill_random();
        load_frame(2, 1'b1, 0);
        finish_pulse();
        start_q.delete();
        for (int i = 0; i < 5; i++) send(i, 1'b0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL mrst_mem_we: got %b want 0", mem_we); end
        n_cmp++; if (mem_addr !== '0 || mem_wdata !== '0) begin n_bad++; $display("FAIL mrst_mem_bus: got %0h/%0h want 0/0", mem_addr, mem_wdata); end
        n_cmp++; if (len_err !== 1'b0) begin n_bad++; $display("FAIL mrst_len_err: got %b want 0", len_err); end
        n_cmp++; if (frame_cnt !== 8'd0) begin n_bad++; $display("FAIL mrst_frame_cnt: got %0d want 0", frame_cnt); end
        n_cmp++; if (s_ready !== 1'b0 || busy !== 1'b0 || fft_start !== 1'b0) begin n_bad++; $display("FAIL mrst_ctrl: got rdy%b busy%b start%b want 000", s_ready, busy, fft_start); end
        rst_n = 1'b1;
        repeat (N + 6) @(negedge clk);
        #1;
        n_cmp++; if (start_q.size() != 0) begin n_bad++; $display("FAIL mrst_no_start: got %0d pulses want 0", start_q.size()); end
        fill_random();
        load_frame(N, 1'b1, 0);
        for (int i = 0; i < int'(N); i++) begin
            n_cmp++;
            if (i >= int'(waddr_q.size()) || waddr_q[i] !== exp_addr(i) || wdata_q[i] !== exp_data(i, N)) begin
                n_bad++;
                $display("FAIL mrst_reload[%0d]: got %0d writes, want %0h/%0h", i, waddr_q.size(), exp_addr(i), exp_data(i, N));
            end
        end
        finish_pulse();
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_short_frame();
        test_gaps();
        test_finish_ignored();
        test_random_frames();
        test_wrap();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
